alu_sequencer: RTL and testbench

- Controller that runs one two-operand ALU instruction end to end.
- Fetches the 16-bit dst and src words from byte-wide memory (two byte reads each).
- Presents them with the opcode to the registered ALU, captures result and PSW, and writes the result back to dst.
- Owns the architectural PSW register, so carry chains across instructions (addc/subc/rrc). Sits between the instruction decoder (start/done handshake) and the byte memory plus ALU.

---
 rtl/alu_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Two-operand ALU instruction sequencer: byte-wide operand fetch, registered ALU handshake,
// PSW ownership and result writeback. Optional completed-op counter under ALU_SEQ_OP_COUNT_EN.
module alu_sequencer #(
  parameter int unsigned AW  = 16,
  parameter int unsigned OPW = 5
) (
  input  logic           Clock,
  input  logic           Reset_n,
  input  logic           start,
  input  logic [OPW-1:0] op,
  input  logic [AW-1:0]  dst_addr,
  input  logic [AW-1:0]  src_addr,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic           mem_rd,
  output logic           mem_wr,
  output logic [AW-1:0]  mem_addr,
  output logic [7:0]     mem_wdata,
  input  logic [7:0]     mem_rdata,
  output logic           alu_go,
  output logic [OPW-1:0] alu_op,
  output logic [15:0]    alu_dst,
  output logic [15:0]    alu_src,
  output logic [15:0]    alu_psw_in,
  input  logic [15:0]    alu_result,
  input  logic [15:0]    alu_psw_out,
  output logic [15:0]    psw,
  input  logic           psw_ld,
  input  logic [15:0]    psw_din,
  output logic [15:0]    op_count
);

  localparam logic [OPW-1:0] OpIllegalMin = OPW'(28);
  localparam logic [OPW-1:0] OpCmpPair    = OPW'(5);
  localparam logic [OPW-1:0] OpBitPair    = OPW'(9);

  typedef enum logic [3:0] {
    StIdle, StRdDl, StRdDh, StRdSl, StRdSh, StCap, StExec, StWait, StWbL, StWbH, StDone
  } state_e;

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q;
  logic [AW-1:0]  dst_addr_q, src_addr_q;
  logic [AW-1:0]  dst_addr_inc, src_addr_inc;
  logic [15:0]    dst_q, src_q, result_q, psw_q;
  logic           op_illegal, op_no_wb, op_byte;
  logic           mem_rd_raw, mem_wr_raw;

  assign dst_addr_inc = dst_addr_q + AW'(1);
  assign src_addr_inc = src_addr_q + AW'(1);

  assign op_illegal = (op_q >= OpIllegalMin);
  assign op_byte    = op_q[0];
  // cmp and bit only update flags; illegal ops never write memory
  assign op_no_wb   = op_illegal || ((op_q >> 1) == OpCmpPair) || ((op_q >> 1) == OpBitPair);

  // State register
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StRdDl;
      StRdDl: state_d = StRdDh;
      StRdDh: state_d = StRdSl;
      StRdSl: state_d = StRdSh;
      StRdSh: state_d = StCap;
      StCap:  state_d = StExec;
      StExec: state_d = StWait;
      StWait: state_d = op_no_wb ? StDone : StWbL;
      StWbL:  state_d = op_byte ? StDone : StWbH;
      StWbH:  state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Instruction latch, operand capture, result and PSW
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      op_q       <= '0;
      dst_addr_q <= '0;
      src_addr_q <= '0;
      dst_q      <= '0;
      src_q      <= '0;
      result_q   <= '0;
      psw_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q       <= op;
            dst_addr_q <= dst_addr;
            src_addr_q <= src_addr;
          end else if (psw_ld) begin
            psw_q <= psw_din;
          end
        end
        StRdDh: dst_q[7:0]  <= mem_rdata;
        StRdSl: dst_q[15:8] <= mem_rdata;
        StRdSh: src_q[7:0]  <= mem_rdata;
        StCap:  src_q[15:8] <= mem_rdata;
        StWait: begin
          result_q <= alu_result;
          if (!op_illegal) psw_q <= alu_psw_out;
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    mem_rd_raw = 1'b0;
    mem_wr_raw = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    alu_go     = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    unique case (state_q)
      StRdDl: begin
        mem_rd_raw = 1'b1;
        mem_addr   = dst_addr_q;
      end
      StRdDh: begin
        mem_rd_raw = 1'b1;
        mem_addr   = dst_addr_inc;
      end
      StRdSl: begin
        mem_rd_raw = 1'b1;
        mem_addr   = src_addr_q;
      end
      StRdSh: begin
        mem_rd_raw = 1'b1;
        mem_addr   = src_addr_inc;
      end
      StExec: alu_go = 1'b1;
      StWbL: begin
        mem_wr_raw = 1'b1;
        mem_addr   = dst_addr_q;
        mem_wdata  = result_q[7:0];
      end
      StWbH: begin
        mem_wr_raw = 1'b1;
        mem_addr   = dst_addr_inc;
        mem_wdata  = result_q[15:8];
      end
      StDone: begin
        done = 1'b1;
        err  = op_illegal;
      end
      default: ;
    endcase
  end

  // Reset kills an in-flight strobe in the same cycle rather than at the next edge
  assign mem_rd = mem_rd_raw & Reset_n;
  assign mem_wr = mem_wr_raw & Reset_n;

  assign busy = (state_q != StIdle);
  assign psw  = psw_q;

  // Operands are only presented while the ALU is working on them
  always_comb begin
    alu_op     = '0;
    alu_dst    = '0;
    alu_src    = '0;
    alu_psw_in = '0;
    if (state_q == StExec || state_q == StWait) begin
      alu_op     = op_q;
      alu_dst    = dst_q;
      alu_src    = src_q;
      alu_psw_in = psw_q;
    end
  end

`ifdef ALU_SEQ_OP_COUNT_EN
  logic [15:0] op_count_q;

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      op_count_q <= '0;
    end else if (state_q == StDone && !op_illegal) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign op_count = op_count_q;
`else
  assign op_count = '0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: byte memory and registered ALU models, scoreboard queues
// for reads, writes and ALU operands, immediate-assertion checks.
module tb_alu_sequencer;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        start;
  logic [4:0]  op;
  logic [15:0] dst_addr, src_addr;
  logic        busy, done, err, mem_rd, mem_wr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        alu_go;
  logic [4:0]  alu_op;
  logic [15:0] alu_dst, alu_src, alu_psw_in, alu_result, alu_psw_out;
  logic [15:0] psw, psw_din, op_count;
  logic        psw_ld;

  alu_sequencer #(.AW(16), .OPW(5)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .start(start), .op(op),
    .dst_addr(dst_addr), .src_addr(src_addr), .busy(busy), .done(done), .err(err),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .alu_go(alu_go), .alu_op(alu_op), .alu_dst(alu_dst),
    .alu_src(alu_src), .alu_psw_in(alu_psw_in), .alu_result(alu_result),
    .alu_psw_out(alu_psw_out), .psw(psw), .psw_ld(psw_ld), .psw_din(psw_din),
    .op_count(op_count)
  );

  always #5 Clock = ~Clock;

`ifdef ALU_SEQ_OP_COUNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  typedef struct packed {logic [15:0] a; logic [7:0] d;} wr_t;
  typedef struct packed {logic [4:0] op; logic [15:0] d; logic [15:0] s; logic [15:0] p;} ex_t;

  logic [7:0]  mem [65536];
  logic [15:0] rd_q[$];
  wr_t         wr_q[$];
  ex_t         ex_q[$];
  ex_t         ex_last;
  logic        hold_pending = 1'b0;
  logic [15:0] exp_psw = '0;
  int          exp_cnt = 0;
  int          nchk = 0;
  int          nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Registered two-operand ALU: add/addc/cmp/bit, illegal ops return an all-ones PSW
  function automatic logic [31:0] alu_model(input logic [4:0] o, input logic [15:0] a, b,
                                            input logic [15:0] pin);
    logic [15:0] bb, r;
    logic [16:0] sum;
    logic        cin, c, z, n, v;
    if (o >= 5'b11100) return {16'h0000, 16'hFFFF};
    bb  = b;
    cin = 1'b0;
    case (o[4:1])
      4'b0001: cin = pin[0];
      4'b0101: begin bb = ~b; cin = 1'b1; end
      default: ;
    endcase
    if (o[4:1] == 4'b1001) begin
      r = o[0] ? {8'h00, a[7:0] & b[7:0]} : (a & b);
      z = (r == 16'h0000);
      n = o[0] ? r[7] : r[15];
      c = !z;
      v = 1'b0;
    end else if (o[0]) begin
      sum = {9'd0, a[7:0]} + {9'd0, bb[7:0]} + {16'd0, cin};
      r   = {8'h00, sum[7:0]};
      c   = sum[8];
      z   = (r[7:0] == 8'h00);
      n   = r[7];
      v   = (a[7] == bb[7]) && (r[7] != a[7]);
    end else begin
      sum = {1'b0, a} + {1'b0, bb} + {16'd0, cin};
      r   = sum[15:0];
      c   = sum[16];
      z   = (r == 16'h0000);
      n   = r[15];
      v   = (a[15] == bb[15]) && (r[15] != a[15]);
    end
    return {r, 11'd0, v, 1'b0, n, z, c};
  endfunction

  always @(posedge Clock) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (alu_go) {alu_result, alu_psw_out} <= alu_model(alu_op, alu_dst, alu_src, alu_psw_in);
  end

  // Bus monitor: every strobe is matched against the scoreboard
  always @(negedge Clock) begin
    if (mem_rd || mem_wr) chk("rd_wr_exclusive", {31'd0, mem_rd & mem_wr}, 32'd0);
    if (mem_rd) begin
      chk("rd_expected", {31'd0, rd_q.size() > 0}, 32'd1);
      if (rd_q.size() > 0) chk("rd_addr", {16'd0, mem_addr}, {16'd0, rd_q.pop_front()});
    end
    if (mem_wr) begin
      chk("wr_expected", {31'd0, wr_q.size() > 0}, 32'd1);
      if (wr_q.size() > 0) begin
        wr_t w;
        w = wr_q.pop_front();
        chk("wr_addr", {16'd0, mem_addr}, {16'd0, w.a});
        chk("wr_data", {24'd0, mem_wdata}, {24'd0, w.d});
      end
    end
    if (alu_go) begin
      chk("exec_expected", {31'd0, ex_q.size() > 0}, 32'd1);
      if (ex_q.size() > 0) begin
        ex_last = ex_q.pop_front();
        chk("alu_op", {27'd0, alu_op}, {27'd0, ex_last.op});
        chk("alu_operands", {alu_dst, alu_src}, {ex_last.d, ex_last.s});
        chk("alu_psw_in", {16'd0, alu_psw_in}, {16'd0, ex_last.p});
        hold_pending = 1'b1;
      end
    end else if (hold_pending) begin
      chk("alu_hold_op", {27'd0, alu_op}, {27'd0, ex_last.op});
      chk("alu_hold_operands", {alu_dst, alu_src}, {ex_last.d, ex_last.s});
      hold_pending = 1'b0;
    end
  end

  // Runs one instruction starting in the current IDLE cycle; ends in the following IDLE cycle
  task automatic run_op(input logic [4:0] o, input logic [15:0] da, sa, dv, sv,
                        input int lat, input logic e, input logic [15:0] p, input bit poke);
    int          cyc;
    logic [15:0] da1, sa1;
    da1 = da + 16'd1;
    sa1 = sa + 16'd1;
    mem[da]  <= dv[7:0];
    mem[da1] <= dv[15:8];
    mem[sa]  <= sv[7:0];
    mem[sa1] <= sv[15:8];
    rd_q.push_back(da);
    rd_q.push_back(da1);
    rd_q.push_back(sa);
    rd_q.push_back(sa1);
    ex_q.push_back({o, dv, sv, exp_psw});
    start    = 1'b1;
    op       = o;
    dst_addr = da;
    src_addr = sa;
    tick();
    start  = 1'b0;
    psw_ld = 1'b0;
    cyc    = 1;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    while (done !== 1'b1 && cyc < 20) begin
      if (poke && cyc == 3) begin
        start    = 1'b1;
        dst_addr = 16'h0300;
        src_addr = 16'h0310;
      end
      if (poke && cyc == 5) start = 1'b0;
      tick();
      cyc++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("latency", cyc, lat);
    chk("err", {31'd0, err}, {31'd0, e});
    chk("psw", {16'd0, psw}, {16'd0, p});
    exp_psw = p;
    if (!e) exp_cnt++;
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("op_count", {16'd0, op_count}, CntEn ? exp_cnt : 0);
  endtask

  initial begin
    Reset_n  = 1'b0;
    start    = 1'b0;
    op       = '0;
    dst_addr = '0;
    src_addr = '0;
    psw_ld   = 1'b0;
    psw_din  = '0;
    tick();
    tick();
    chk("rst_ctrl", {26'd0, busy, done, err, mem_rd, mem_wr, alu_go}, 32'd0);
    chk("rst_mem", {8'd0, mem_addr, mem_wdata}, 32'd0);
    chk("rst_alu_op", {27'd0, alu_op}, 32'd0);
    chk("rst_alu_operands", {alu_dst, alu_src}, 32'd0);
    chk("rst_psw_count", {psw, op_count}, 32'd0);
    Reset_n = 1'b1;
    tick();

    // add word: 0x1234 + 0x1111
    wr_q.push_back({16'h0010, 8'h45});
    wr_q.push_back({16'h0011, 8'h23});
    run_op(5'b00000, 16'h0010, 16'h0020, 16'h1234, 16'h1111, 10, 1'b0, 16'h0000, 1'b0);
    chk("add_mem", {mem[16'h0011], mem[16'h0010]}, 32'h2345);

    // add.b: 0xFF + 0x01 -> 0x00, C and Z set, high byte untouched
    wr_q.push_back({16'h0030, 8'h00});
    run_op(5'b00001, 16'h0030, 16'h0040, 16'hABFF, 16'h0001, 9, 1'b0, 16'h0003, 1'b0);
    chk("addb_hi_untouched", {24'd0, mem[16'h0031]}, 32'h00AB);

    // psw load, then start beats a simultaneous psw_ld; addc consumes carry
    psw_ld  = 1'b1;
    psw_din = 16'h0001;
    tick();
    psw_ld = 1'b0;
    chk("psw_load", {16'd0, psw}, 32'h0001);
    exp_psw = 16'h0001;
    psw_ld  = 1'b1;
    psw_din = 16'h00F0;
    wr_q.push_back({16'h0050, 8'h03});
    wr_q.push_back({16'h0051, 8'h00});
    run_op(5'b00010, 16'h0050, 16'h0060, 16'h0001, 16'h0001, 10, 1'b0, 16'h0000, 1'b0);

    // cmp with dst_addr == src_addr: no writeback, Z and C from ALU
    run_op(5'b01010, 16'h0070, 16'h0070, 16'h5555, 16'h5555, 8, 1'b0, 16'h0003, 1'b0);

    // illegal op with a stray start while busy: err, psw kept, nothing written
    run_op(5'b11111, 16'h0090, 16'h00A0, 16'h1111, 16'h2222, 8, 1'b1, 16'h0003, 1'b1);

    // dst word straddles the top of the address space
    wr_q.push_back({16'hFFFF, 8'h11});
    wr_q.push_back({16'h0000, 8'h02});
    run_op(5'b00000, 16'hFFFF, 16'h0100, 16'h0201, 16'h0010, 10, 1'b0, 16'h0000, 1'b0);
    chk("wrap_mem", {mem[16'h0000], mem[16'hFFFF]}, 32'h0211);

    // reset during WB_L aborts the write and never reaches WB_H
    mem[16'h0200] <= 8'h01;
    mem[16'h0201] <= 8'h00;
    mem[16'h0210] <= 8'h02;
    mem[16'h0211] <= 8'h00;
    rd_q.push_back(16'h0200);
    rd_q.push_back(16'h0201);
    rd_q.push_back(16'h0210);
    rd_q.push_back(16'h0211);
    ex_q.push_back({5'b00000, 16'h0001, 16'h0002, exp_psw});
    start    = 1'b1;
    op       = 5'b00000;
    dst_addr = 16'h0200;
    src_addr = 16'h0210;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("wbl_strobe", {31'd0, mem_wr}, 32'd1);
    chk("wbl_addr", {16'd0, mem_addr}, 32'h0200);
    Reset_n = 1'b0;
    #1;
    chk("wr_abort", {31'd0, mem_wr}, 32'd0);
    tick();
    chk("rst2_ctrl", {26'd0, busy, done, err, mem_rd, mem_wr, alu_go}, 32'd0);
    chk("rst2_mem", {8'd0, mem_addr, mem_wdata}, 32'd0);
    chk("rst2_alu", {alu_dst, 11'd0, alu_op}, 32'd0);
    chk("rst2_psw_count", {psw, op_count}, 32'd0);
    Reset_n = 1'b1;
    exp_psw = '0;
    exp_cnt = 0;
    tick();
    tick();
    chk("abort_no_wbl", {24'd0, mem[16'h0200]}, 32'h0001);
    chk("abort_no_wbh", {24'd0, mem[16'h0201]}, 32'h0000);
    chk("idle_after_abort", {31'd0, busy}, 32'd0);

    chk("rd_q_drained", rd_q.size(), 0);
    chk("wr_q_drained", wr_q.size(), 0);
    chk("ex_q_drained", ex_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
